// File: rtl/traffic_pkg.sv
// Shared types and lamp encodings for the traffic light controller.
package traffic_pkg;

    localparam int unsigned PHASE_W = 2;
    localparam int unsigned LAMP_W  = 3;

    typedef enum logic [PHASE_W-1:0] {
        RED       = 2'd0,
        RED_AMBER = 2'd1,
        GREEN     = 2'd2,
        AMBER     = 2'd3
    } phase_t;

    // Lamp patterns ordered {red, amber, green}
    localparam logic [LAMP_W-1:0] LAMP_RED   = 3'b100;
    localparam logic [LAMP_W-1:0] LAMP_RA    = 3'b110;
    localparam logic [LAMP_W-1:0] LAMP_GREEN = 3'b001;
    localparam logic [LAMP_W-1:0] LAMP_AMBER = 3'b010;

    // Lamp pattern shown while in a given phase
    function automatic logic [LAMP_W-1:0] lamp_of(input phase_t p);
        logic [LAMP_W-1:0] l;
        l = LAMP_RED;
        case (p)
            RED:       l = LAMP_RED;
            RED_AMBER: l = LAMP_RA;
            GREEN:     l = LAMP_GREEN;
            AMBER:     l = LAMP_AMBER;
            default:   l = LAMP_RED;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_ctrl_phase_timer.sv
// Phase timer: counts enabled cycles in the current phase, flags the last one.
module phase_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] dur,
    output logic [CNT_W-1:0] cnt,
    output logic             done_c
);

    // Counter: synchronous clear has priority over counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Last cycle of the phase
    assign done_c = (cnt == (dur - CNT_W'(1)));

endmodule

// File: rtl/traffic_ctrl.sv
// Single-junction traffic light controller with programmable phase lengths.
// Optional pedestrian channel compiled in with TRAFFIC_PED_EN.
module traffic_ctrl #(
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned RED_CYC   = 4,
    parameter int unsigned RA_CYC    = 2,
    parameter int unsigned GREEN_CYC = 6,
    parameter int unsigned AMBER_CYC = 2,
    parameter int unsigned MIN_GREEN = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       ped_req,
    output logic       ped_ack,
    output logic       walk,
    output logic       red,
    output logic       amber,
    output logic       green,
    output logic [1:0] phase
);
    import traffic_pkg::*;

    localparam int unsigned DUR_MAX = (1 << CNT_W) - 1;
    localparam bit PARAM_OK =
        (RED_CYC   >= 1) && (RED_CYC   <= DUR_MAX) &&
        (RA_CYC    >= 1) && (RA_CYC    <= DUR_MAX) &&
        (GREEN_CYC >= 1) && (GREEN_CYC <= DUR_MAX) &&
        (AMBER_CYC >= 1) && (AMBER_CYC <= DUR_MAX) &&
        (MIN_GREEN >= 1) && (MIN_GREEN <= GREEN_CYC);

    // Reject illegal duration settings at elaboration
    if (!PARAM_OK) begin : g_param_err
        $error("traffic_ctrl: illegal phase duration parameters");
    end

    phase_t           state_q, state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] dur;
    logic             done_c;
    logic             early_c;
    logic             adv_c;

    // Duration of the current phase
    always_comb begin
        dur = '0;
        case (state_q)
            RED:       dur = CNT_W'(RED_CYC);
            RED_AMBER: dur = CNT_W'(RA_CYC);
            GREEN:     dur = CNT_W'(GREEN_CYC);
            AMBER:     dur = CNT_W'(AMBER_CYC);
            default:   dur = CNT_W'(RED_CYC);
        endcase
    end

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (enable),
        .clr    (adv_c),
        .dur    (dur),
        .cnt    (cnt),
        .done_c (done_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RED;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: advance cyclically at phase end or on early green cut
    always_comb begin
        state_d = state_q;
        adv_c   = enable && (done_c || early_c);
        if (adv_c) begin
            case (state_q)
                RED:       state_d = RED_AMBER;
                RED_AMBER: state_d = GREEN;
                GREEN:     state_d = AMBER;
                AMBER:     state_d = RED;
                default:   state_d = RED;
            endcase
        end
    end

    // Lamp registers track the state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {red, amber, green} <= LAMP_RED;
        end else begin
            {red, amber, green} <= lamp_of(state_d);
        end
    end

    assign phase = state_q;

`ifdef TRAFFIC_PED_EN
    logic pend_q;
    logic walk_q;
    logic ack_q;
    logic enter_red_c;

    assign enter_red_c = adv_c && (state_q == AMBER);
    assign early_c     = (state_q == GREEN) && pend_q &&
                         (cnt >= CNT_W'(MIN_GREEN - 1));

    // Pending request, walk lamp and acknowledge pulse; a new request beats the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
            walk_q <= 1'b0;
            ack_q  <= 1'b0;
        end else begin
            pend_q <= ped_req || (pend_q && !enter_red_c);
            ack_q  <= enter_red_c && pend_q;
            if (enter_red_c) begin
                walk_q <= pend_q;
            end else if (adv_c && (state_q == RED)) begin
                walk_q <= 1'b0;
            end
        end
    end

    assign walk    = walk_q;
    assign ped_ack = ack_q;
`else
    logic unused_ped;

    assign unused_ped = ^{ped_req, cnt};
    assign early_c    = 1'b0;
    assign walk       = 1'b0;
    assign ped_ack    = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_ctrl.sv
// Self-checking bench for traffic_ctrl: phase-level reference model plus directed scenarios and random stimulus.
module tb_traffic_ctrl;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       enable  = 1'b0;
    logic       ped_req = 1'b0;
    logic       ped_ack;
    logic       walk;
    logic       red;
    logic       amber;
    logic       green;
    logic [1:0] phase;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    traffic_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .ped_req (ped_req),
        .ped_ack (ped_ack),
        .walk    (walk),
        .red     (red),
        .amber   (amber),
        .green   (green),
        .phase   (phase)
    );

    always #5 clk = ~clk;

    // Reference model: phase index, cycles elapsed in phase, pedestrian flags
    int         durs[4]     = '{4, 2, 6, 2};
    logic [2:0] lamp_tab[4] = '{3'b100, 3'b110, 3'b001, 3'b010};
    int         m_ph;
    int         m_el;
    bit         m_pend;
    bit         m_walk;
    bit         m_ack;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph   = 0;
        m_el   = 0;
        m_pend = 1'b0;
        m_walk = 1'b0;
        m_ack  = 1'b0;
    endtask

    task automatic model_step();
        bit np;
        bit leave;
        np    = m_pend;
        m_ack = 1'b0;
`ifdef TRAFFIC_PED_EN
        np = m_pend | ped_req;
`endif
        if (enable) begin
            m_el  = m_el + 1;
            leave = (m_el == durs[m_ph]);
`ifdef TRAFFIC_PED_EN
            if (m_ph == 2 && m_pend && m_el >= 2) leave = 1'b1;
            if (leave && m_ph == 3) begin
                m_walk = m_pend;
                if (m_pend) begin
                    m_ack = 1'b1;
                    np    = ped_req;
                end
            end
`endif
            if (leave && m_ph == 0) m_walk = 1'b0;
            if (leave) begin
                m_ph = (m_ph + 1) % 4;
                m_el = 0;
            end
        end
        m_pend = np;
    endtask

    // Advance the model on every edge and compare shortly after it
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else        model_step();
            #1;
            if (chk_en) begin
                chk("phase",   32'(phase),               32'(m_ph));
                chk("lamps",   32'({red, amber, green}), 32'(lamp_tab[m_ph]));
                chk("walk",    32'(walk),                32'(m_walk));
                chk("ped_ack", 32'(ped_ack),             32'(m_ack));
            end
        end
    end

    // Sample at negedge until phase p is shown (bounded)
    task automatic wait_phase(input int p);
        int n;
        n = 0;
        while (phase !== 2'(p) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("reach_phase", 32'(phase), 32'(p));
    endtask

    // Count consecutive negedge samples showing phase p
    task automatic run_len(input int p, output int n);
        n = 0;
        while (phase === 2'(p) && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        int ng;
        int nw;
        int nbad;

        rst_n   = 1'b0;
        enable  = 1'b1;
        ped_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_phase", 32'(phase),               0);
        chk("rst_lamps", 32'({red, amber, green}), 32'(3'b100));
        chk("rst_walk",  32'(walk),                0);
        chk("rst_ack",   32'(ped_ack),             0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Two uninterrupted cycles
        ng = 0; nw = 0; nbad = 0;
        for (int i = 0; i < 28; i++) begin
            if (i == 0)  chk("seq_red0",   32'(phase), 0);
            if (i == 4)  chk("seq_ra0",    32'(phase), 1);
            if (i == 6)  chk("seq_green0", 32'(phase), 2);
            if (i == 12) chk("seq_amber0", 32'(phase), 3);
            if (i == 14) chk("seq_red1",   32'(phase), 0);
            ng += int'(green);
            nw += int'(walk);
            if ({red, amber, green} == 3'b000 || {red, amber, green} == 3'b101 ||
                {red, amber, green} == 3'b111 || {red, amber, green} == 3'b011) nbad++;
            @(negedge clk);
        end
        chk("green_cycles_28", 32'(ng),   12);
        chk("walk_cycles_28",  32'(nw),   0);
        chk("illegal_lamps",   32'(nbad), 0);
        chk("seq_wrap",        32'(phase), 0);

        // Freeze for five cycles at green timer 3
        wait_phase(2);
        repeat (3) @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("freeze_phase", 32'(phase), 2);
            chk("freeze_green", 32'(green), 1);
        end
        enable = 1'b1;
        run_len(2, n);
        chk("green_rest", 32'(n), 3);

`ifdef TRAFFIC_PED_EN
        // Request in green cycle 0 cuts green to the minimum
        wait_phase(0);
        wait_phase(2);
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        run_len(2, n);
        chk("ped_green_len", 32'(n + 1), 2);
        run_len(3, n);
        chk("ped_amber_len",  32'(n), 2);
        chk("ack_first_red",  32'(ped_ack), 1);
        chk("walk_first_red", 32'(walk), 1);
        @(negedge clk);
        chk("ack_pulse_end", 32'(ped_ack), 0);
        run_len(0, n);
        chk("walk_red_len",   32'(n + 1), 4);
        chk("walk_after_red", 32'(walk), 0);

        // Request during red-amber, then a second one on the ack edge
        wait_phase(1);
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        wait_phase(2);
        run_len(2, n);
        chk("ra_req_green_len", 32'(n), 2);
        @(negedge clk);
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        chk("ack2_first_red",  32'(ped_ack), 1);
        chk("walk2_first_red", 32'(walk), 1);
        run_len(0, n);
        chk("red2_len", 32'(n), 4);
        wait_phase(2);
        run_len(2, n);
        chk("rearmed_green_len", 32'(n), 2);
        wait_phase(0);
        chk("rearmed_walk", 32'(walk), 1);

        // Async reset mid-amber with a pending request
        @(negedge clk);
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        wait_phase(3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_red",   32'(red),   1);
        chk("async_walk",  32'(walk),  0);
        chk("async_phase", 32'(phase), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ng = 0; nw = 0;
        for (int i = 0; i < 14; i++) begin
            ng += int'(green);
            nw += int'(walk) + int'(ped_ack);
            @(negedge clk);
        end
        chk("post_rst_green", 32'(ng), 6);
        chk("post_rst_walk",  32'(nw), 0);
        chk("post_rst_wrap",  32'(phase), 0);
`else
        // Requests ignored without the pedestrian channel
        ped_req = 1'b1;
        wait_phase(0);
        wait_phase(2);
        run_len(2, n);
        chk("noped_green_len", 32'(n), 6);
        chk("noped_walk",      32'(walk), 0);
        chk("noped_ack",       32'(ped_ack), 0);
        ped_req = 1'b0;
`endif

        // Random enable / request traffic with rare resets
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            enable  = ($urandom_range(0, 7) != 0);
            ped_req = ($urandom_range(0, 5) == 0);
            rst_n   = ($urandom_range(0, 199) != 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
